// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-clock FIFO read side.
package fifo_pkg;

  // Occupancy of the 2-entry first-word-fall-through output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Pointers carry one extra lap bit above the memory address.
  function automatic int unsigned pointer_width(input int unsigned address_size);
    return address_size + 1;
  endfunction

endpackage

// File: rtl/read_side_fwft_if.sv
// Valid/ready output handshake of the read side.
interface read_side_fwft_if #(
  parameter int unsigned data_width = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/read_side_fwft_read_empty.sv
// Read pointer and registered empty / fill-level / almost-empty flags.
module read_empty
  import fifo_pkg::*;
#(
  parameter int unsigned address_size       = 4,
  parameter int unsigned almost_empty_level = 2
) (
  input  logic                                     read_clk,
  input  logic                                     rreset_n,
  input  logic                                     read_inc,
  input  logic [pointer_width(address_size)-1:0]   write_pointer_s,
  output logic [pointer_width(address_size)-1:0]   read_pointer,
  output logic                                     read_empty,
  output logic [pointer_width(address_size)-1:0]   fill_level,
  output logic                                     almost_empty
);

  localparam int unsigned PW = pointer_width(address_size);

  logic [PW-1:0] read_pointer_next;
  logic [PW-1:0] fill_next;

  // Next pointer and the fill it leaves behind, both wrapping modulo 2**PW.
  always_comb begin
    read_pointer_next = read_pointer + PW'(read_inc);
    fill_next         = write_pointer_s - read_pointer_next;
  end

  // Pointer and flags updated together so a write advance and a read land in one update.
  always_ff @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      read_pointer <= '0;
      read_empty   <= 1'b1;
      fill_level   <= '0;
      almost_empty <= 1'b1;
    end else begin
      read_pointer <= read_pointer_next;
      read_empty   <= (read_pointer_next == write_pointer_s);
      fill_level   <= fill_next;
      almost_empty <= (fill_next <= PW'(almost_empty_level));
    end
  end

endmodule

// File: rtl/read_side_fwft.sv
// Read-side FIFO controller: memory read credit logic and 2-entry FWFT output buffer.
module read_side_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned address_size       = 4,
  parameter int unsigned data_width         = 8,
  parameter int unsigned almost_empty_level = 2
) (
  input  logic                                     read_clk,
  input  logic                                     rreset_n,
  input  logic [pointer_width(address_size)-1:0]   write_pointer_s,
  output logic [pointer_width(address_size)-1:0]   read_pointer,
  output logic [address_size-1:0]                  read_address,
  output logic                                     read_en,
  input  logic [data_width-1:0]                    read_data_mem,
  output logic                                     read_empty,
  output logic [pointer_width(address_size)-1:0]   fill_level,
  output logic                                     almost_empty,
  read_side_fwft_if.master                         fwft
);

  buf_state_t            state;
  buf_state_t            state_next;
  logic                  inflight;
  logic [data_width-1:0] head;
  logic [data_width-1:0] skid;
  logic [data_width-1:0] head_next;
  logic [data_width-1:0] skid_next;
  logic                  pop;
  logic [1:0]            occupancy;

  assign fwft.out_valid = (state != EMPTY);
  assign fwft.out_data  = head;
  assign read_address   = read_pointer[address_size-1:0];

  // Fetch only while buffered plus in-flight words stay within the two buffer slots.
  always_comb begin
    pop       = fwft.out_valid & fwft.out_ready;
    occupancy = 2'(state) + 2'(inflight);
    read_en   = ~read_empty & ((occupancy < 2'd2) | pop);
  end

  read_empty #(
    .address_size       (address_size),
    .almost_empty_level (almost_empty_level)
  ) u_read_empty (
    .read_clk        (read_clk),
    .rreset_n        (rreset_n),
    .read_inc        (read_en),
    .write_pointer_s (write_pointer_s),
    .read_pointer    (read_pointer),
    .read_empty      (read_empty),
    .fill_level      (fill_level),
    .almost_empty    (almost_empty)
  );

  // Buffer state, data registers and the in-flight marker for the 1-cycle memory latency.
  always_ff @(posedge read_clk or negedge rreset_n) begin
    if (!rreset_n) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      state    <= state_next;
      inflight <= read_en;
      head     <= head_next;
      skid     <= skid_next;
    end
  end

  // Place arriving words and retire popped ones, preserving order head-then-skid.
  always_comb begin
    state_next = state;
    head_next  = head;
    skid_next  = skid;
    unique case (state)
      EMPTY: begin
        if (inflight) begin
          head_next  = read_data_mem;
          state_next = ONE;
        end
      end
      ONE: begin
        if (inflight && pop) begin
          head_next = read_data_mem;
        end else if (inflight) begin
          skid_next  = read_data_mem;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_next = skid;
          if (inflight) begin
            skid_next = read_data_mem;
          end else begin
            state_next = ONE;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_read_side_fwft.sv
// Directed bench for the read-side FWFT controller with a 1-cycle synchronous memory model.
module tb_read_side_fwft;

  logic       read_clk;
  logic       rreset_n;
  logic [4:0] write_pointer_s;
  logic [4:0] read_pointer;
  logic [3:0] read_address;
  logic       read_en;
  logic [7:0] read_data_mem;
  logic       read_empty;
  logic [4:0] fill_level;
  logic       almost_empty;

  int checks;
  int failures;

  logic [7:0] mem [16];

  read_side_fwft_if #(.data_width(8)) fwft_if ();

  read_side_fwft #(
    .address_size       (4),
    .data_width         (8),
    .almost_empty_level (2)
  ) dut (
    .read_clk        (read_clk),
    .rreset_n        (rreset_n),
    .write_pointer_s (write_pointer_s),
    .read_pointer    (read_pointer),
    .read_address    (read_address),
    .read_en         (read_en),
    .read_data_mem   (read_data_mem),
    .read_empty      (read_empty),
    .fill_level      (fill_level),
    .almost_empty    (almost_empty),
    .fwft            (fwft_if)
  );

  always #5 read_clk = ~read_clk;

  // Synchronous-read memory: data appears the cycle after read_en.
  always @(posedge read_clk) begin
    if (read_en) read_data_mem <= mem[read_address];
  end

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic do_reset();
    rreset_n          = 1'b0;
    write_pointer_s   = '0;
    fwft_if.out_ready = 1'b0;
    tick();
    tick();
    rreset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rreset_n          = 1'b0;
    write_pointer_s   = '0;
    fwft_if.out_ready = 1'b0;
    tick();
    checks++; if (read_pointer !== 5'd0) begin failures++; $display("FAIL reset_rp: got %0d exp 0", read_pointer); end
    checks++; if (read_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b exp 1", read_empty); end
    checks++; if (fill_level !== 5'd0) begin failures++; $display("FAIL reset_fill: got %0d exp 0", fill_level); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae: got %b exp 1", almost_empty); end
    checks++; if (fwft_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", fwft_if.out_valid); end
    checks++; if (fwft_if.out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h exp 00", fwft_if.out_data); end
    rreset_n = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (read_pointer !== 5'd0 || read_empty !== 1'b1 || fill_level !== 5'd0 ||
                  almost_empty !== 1'b1 || fwft_if.out_valid !== 1'b0 || read_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rp=%0d empty=%b fill=%0d ae=%b valid=%b ren=%b exp 0 1 0 1 0 0",
               read_pointer, read_empty, fill_level, almost_empty, fwft_if.out_valid, read_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    write_pointer_s   = 5'd1;
    fwft_if.out_ready = 1'b1;
    tick();
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL single_ren: got %b exp 1", read_en); end
    checks++; if (read_address !== 4'd0) begin failures++; $display("FAIL single_addr: got %0d exp 0", read_address); end
    checks++; if (fill_level !== 5'd1) begin failures++; $display("FAIL single_fill: got %0d exp 1", fill_level); end
    tick();
    checks++; if (read_empty !== 1'b1) begin failures++; $display("FAIL single_empty_c2: got %b exp 1", read_empty); end
    checks++; if (read_pointer !== 5'd1) begin failures++; $display("FAIL single_rp: got %0d exp 1", read_pointer); end
    checks++; if (fwft_if.out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_c2: got %b exp 0", fwft_if.out_valid); end
    tick();
    checks++; if (fwft_if.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid_c3: got %b exp 1", fwft_if.out_valid); end
    checks++; if (fwft_if.out_data !== 8'h10) begin failures++; $display("FAIL single_data: got %h exp 10", fwft_if.out_data); end
    tick();
    checks++; if (fwft_if.out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after_pop: got %b exp 0", fwft_if.out_valid); end
  endtask

  task automatic test_backpressure();
    int reads;
    do_reset();
    write_pointer_s   = 5'd8;
    fwft_if.out_ready = 1'b0;
    reads = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (read_en) begin
        checks++;
        if (read_address !== 4'(reads)) begin failures++; $display("FAIL bp_addr: got %0d exp %0d", read_address, reads); end
        reads++;
      end
    end
    checks++; if (reads !== 2) begin failures++; $display("FAIL bp_reads: got %0d exp 2", reads); end
    checks++; if (read_pointer !== 5'd2) begin failures++; $display("FAIL bp_rp: got %0d exp 2", read_pointer); end
    checks++; if (fill_level !== 5'd6) begin failures++; $display("FAIL bp_fill: got %0d exp 6", fill_level); end
    checks++; if (fwft_if.out_valid !== 1'b1 || fwft_if.out_data !== 8'h10) begin
      failures++; $display("FAIL bp_head: valid=%b data=%h exp 1 10", fwft_if.out_valid, fwft_if.out_data);
    end
    tick();
    tick();
    checks++; if (fwft_if.out_data !== 8'h10) begin failures++; $display("FAIL bp_stable: got %h exp 10", fwft_if.out_data); end
    fwft_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (fwft_if.out_valid !== 1'b1 || fwft_if.out_data !== 8'(8'h10 + k)) begin
        failures++;
        $display("FAIL bp_stream[%0d]: valid=%b data=%h exp 1 %h", k, fwft_if.out_valid, fwft_if.out_data, 8'(8'h10 + k));
      end
      tick();
    end
    checks++; if (fwft_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b exp 0", fwft_if.out_valid); end
    checks++; if (read_pointer !== 5'd8 || read_empty !== 1'b1 || fill_level !== 5'd0) begin
      failures++; $display("FAIL bp_final: rp=%0d empty=%b fill=%0d exp 8 1 0", read_pointer, read_empty, fill_level);
    end
  endtask

  task automatic test_wrap();
    int n;
    int m;
    do_reset();
    fwft_if.out_ready = 1'b1;
    write_pointer_s   = 5'd15;
    for (int c = 0; c < 30; c++) tick();
    checks++; if (read_pointer !== 5'd15 || fwft_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL wrap_pre: rp=%0d valid=%b exp 15 0", read_pointer, fwft_if.out_valid);
    end
    write_pointer_s = 5'd17;
    n = 0;
    m = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (read_en) begin
        checks++;
        if (read_address !== ((n == 0) ? 4'd15 : 4'd0)) begin
          failures++; $display("FAIL wrap_addr[%0d]: got %0d exp %0d", n, read_address, (n == 0) ? 15 : 0);
        end
        n++;
      end
      if (fwft_if.out_valid) begin
        checks++;
        if (fwft_if.out_data !== ((m == 0) ? 8'h1f : 8'h10)) begin
          failures++; $display("FAIL wrap_data[%0d]: got %h exp %h", m, fwft_if.out_data, (m == 0) ? 8'h1f : 8'h10);
        end
        m++;
      end
    end
    checks++; if (n !== 2 || m !== 2) begin failures++; $display("FAIL wrap_counts: reads=%0d words=%0d exp 2 2", n, m); end
    checks++; if (read_pointer !== 5'b10001) begin failures++; $display("FAIL wrap_rp: got %b exp 10001", read_pointer); end
    checks++; if (read_empty !== 1'b1 || fill_level !== 5'd0) begin
      failures++; $display("FAIL wrap_flags: empty=%b fill=%0d exp 1 0", read_empty, fill_level);
    end
  endtask

  task automatic test_almost_empty();
    do_reset();
    fwft_if.out_ready = 1'b0;
    write_pointer_s   = 5'd3;
    tick();
    checks++; if (fill_level !== 5'd3 || almost_empty !== 1'b0) begin
      failures++; $display("FAIL ae_fill3: fill=%0d ae=%b exp 3 0", fill_level, almost_empty);
    end
    checks++; if (read_en !== 1'b1) begin failures++; $display("FAIL ae_fetch: got %b exp 1", read_en); end
    tick();
    checks++; if (fill_level !== 5'd2 || almost_empty !== 1'b1) begin
      failures++; $display("FAIL ae_fill2: fill=%0d ae=%b exp 2 1", fill_level, almost_empty);
    end
    tick();
    checks++; if (fill_level !== 5'd1 || almost_empty !== 1'b1) begin
      failures++; $display("FAIL ae_fill1: fill=%0d ae=%b exp 1 1", fill_level, almost_empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_pointer_s   = 5'd8;
    fwft_if.out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (fwft_if.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid: got %b exp 1", fwft_if.out_valid); end
    #2;
    rreset_n = 1'b0;
    #1;
    checks++; if (fwft_if.out_valid !== 1'b0 || read_pointer !== 5'd0 || read_empty !== 1'b1 ||
                  fill_level !== 5'd0 || fwft_if.out_data !== 8'h00) begin
      failures++;
      $display("FAIL ar_immediate: valid=%b rp=%0d empty=%b fill=%0d data=%h exp 0 0 1 0 00",
               fwft_if.out_valid, read_pointer, read_empty, fill_level, fwft_if.out_data);
    end
    write_pointer_s = 5'd0;
    tick();
    rreset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (fwft_if.out_valid !== 1'b0 || read_en !== 1'b0) begin
        failures++; $display("FAIL ar_stale[%0d]: valid=%b ren=%b exp 0 0", c, fwft_if.out_valid, read_en);
      end
    end
    write_pointer_s = 5'd1;
    tick();
    tick();
    tick();
    checks++; if (fwft_if.out_valid !== 1'b1 || fwft_if.out_data !== 8'h10) begin
      failures++; $display("FAIL ar_restart: valid=%b data=%h exp 1 10", fwft_if.out_valid, fwft_if.out_data);
    end
  endtask

  initial begin
    read_clk          = 1'b0;
    rreset_n          = 1'b0;
    write_pointer_s   = '0;
    fwft_if.out_ready = 1'b0;
    read_data_mem     = '0;
    checks            = 0;
    failures          = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_almost_empty();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
